// File: rtl/gsim_pe_if.sv
// ============================================================================
// Module : gsim_pe_if
// Brief  : Operand-in / result-out handshake bundle for the GSIM compute stage.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface gsim_pe_if #(
    parameter int BIT_WIDTH = 32,
    parameter int B_WIDTH   = 16,
    parameter int ITER_MAX  = 8
);
    logic                               in_valid;
    logic                               in_ready;
    logic [B_WIDTH-1:0]                 b_in;
    logic [BIT_WIDTH-1:0]               x_m1;
    logic [BIT_WIDTH-1:0]               x_p1;
    logic [BIT_WIDTH-1:0]               x_m2;
    logic [BIT_WIDTH-1:0]               x_p2;
    logic [BIT_WIDTH-1:0]               x_m3;
    logic [BIT_WIDTH-1:0]               x_p3;
    logic                               out_valid;
    logic                               out_ready;
    logic [BIT_WIDTH-1:0]               x_out;
    logic [3:0]                         out_idx;
    logic [$clog2(ITER_MAX+1)-1:0]      iter_cnt;
    logic                               done;

    modport master (
        output in_valid, b_in, x_m1, x_p1, x_m2, x_p2, x_m3, x_p3, out_ready,
        input  in_ready, out_valid, x_out, out_idx, iter_cnt, done
    );

    modport slave (
        input  in_valid, b_in, x_m1, x_p1, x_m2, x_p2, x_m3, x_p3, out_ready,
        output in_ready, out_valid, x_out, out_idx, iter_cnt, done
    );
endinterface

`default_nettype wire

// File: rtl/gsim_pe.sv
// ============================================================================
// Module : gsim_pe
// Brief  : 3-stage Gauss-Seidel update pipeline with result index/sweep tags.
//          Optional macro GSIM_PE_SAT_EN clamps the result instead of wrapping.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module gsim_pe #(
    parameter int BIT_WIDTH = 32,
    parameter int B_WIDTH   = 16,
    parameter int ITER_MAX  = 8,
    parameter int RECIP     = 838861
) (
    input  wire logic   clk,
    input  wire logic   rst_n,
    gsim_pe_if.slave    bus
);

    localparam int c_SUM_W  = BIT_WIDTH + 1;
    localparam int c_ACC_W  = 40;
    localparam int c_PROD_W = 64;
    localparam int c_R_W    = c_PROD_W - 24;
    localparam int c_ITER_W = $clog2(ITER_MAX + 1);

    localparam logic signed [c_PROD_W-1:0] c_RECIP = c_PROD_W'(RECIP);
    localparam logic signed [c_PROD_W-1:0] c_HALF  = c_PROD_W'(64'h0000_0000_0080_0000);
    localparam logic [c_ITER_W-1:0]        c_ITER_LAST = c_ITER_W'(ITER_MAX - 1);

    // ------------------------------------------------------------------
    // Handshake
    // ------------------------------------------------------------------
    logic w_stall;
    logic w_accept;
    logic w_consume;
    logic w_last;

    logic                       r_v1;
    logic                       r_v2;
    logic                       r_out_valid;
    logic signed [c_SUM_W-1:0]  r_s1;
    logic signed [c_SUM_W-1:0]  r_s2;
    logic signed [c_SUM_W-1:0]  r_s3;
    logic [c_ACC_W-1:0]         r_bq;
    logic signed [c_ACC_W-1:0]  r_acc;
    logic [BIT_WIDTH-1:0]       r_x_out;
    logic [3:0]                 r_idx;
    logic [c_ITER_W-1:0]        r_iter;
    logic                       r_done;

    assign w_stall   = r_out_valid & ~bus.out_ready;
    assign w_accept  = bus.in_valid & ~w_stall;
    assign w_consume = r_out_valid & bus.out_ready;
    assign w_last    = (r_idx == 4'd15) && (r_iter == c_ITER_LAST);

    // ------------------------------------------------------------------
    // Stage 1 operands: pairwise tap sums and b aligned to the Q.16 point
    // ------------------------------------------------------------------
    logic signed [c_SUM_W-1:0] w_s1;
    logic signed [c_SUM_W-1:0] w_s2;
    logic signed [c_SUM_W-1:0] w_s3;
    logic [c_ACC_W-1:0]        w_bq;

    assign w_s1 = $signed({bus.x_m1[BIT_WIDTH-1], bus.x_m1}) + $signed({bus.x_p1[BIT_WIDTH-1], bus.x_p1});
    assign w_s2 = $signed({bus.x_m2[BIT_WIDTH-1], bus.x_m2}) + $signed({bus.x_p2[BIT_WIDTH-1], bus.x_p2});
    assign w_s3 = $signed({bus.x_m3[BIT_WIDTH-1], bus.x_m3}) + $signed({bus.x_p3[BIT_WIDTH-1], bus.x_p3});
    assign w_bq = {{(c_ACC_W-B_WIDTH-16){1'b0}}, bus.b_in, 16'h0000};

    // ------------------------------------------------------------------
    // Stage 2 accumulate: constant multiplies built from shifts
    // ------------------------------------------------------------------
    logic signed [c_ACC_W-1:0] w_s1_ext;
    logic signed [c_ACC_W-1:0] w_s2_ext;
    logic signed [c_ACC_W-1:0] w_s3_ext;
    logic signed [c_ACC_W-1:0] w_s1_x13;
    logic signed [c_ACC_W-1:0] w_s2_x6;
    logic signed [c_ACC_W-1:0] w_acc;

    assign w_s1_ext = {{(c_ACC_W-c_SUM_W){r_s1[c_SUM_W-1]}}, r_s1};
    assign w_s2_ext = {{(c_ACC_W-c_SUM_W){r_s2[c_SUM_W-1]}}, r_s2};
    assign w_s3_ext = {{(c_ACC_W-c_SUM_W){r_s3[c_SUM_W-1]}}, r_s3};
    assign w_s1_x13 = (w_s1_ext <<< 3) + (w_s1_ext <<< 2) + w_s1_ext;
    assign w_s2_x6  = (w_s2_ext <<< 2) + (w_s2_ext <<< 1);
    assign w_acc    = $signed(r_bq) + w_s1_x13 - w_s2_x6 + w_s3_ext;

    // ------------------------------------------------------------------
    // Stage 3: divide by 20 via reciprocal, round half toward +inf
    // ------------------------------------------------------------------
    logic signed [c_PROD_W-1:0] w_acc_wide;
    logic signed [c_PROD_W-1:0] w_prod;
    logic signed [c_PROD_W-1:0] w_rnd;
    logic signed [c_R_W-1:0]    w_r;
    logic [BIT_WIDTH-1:0]       w_x;
    logic                       w_unused_rnd;

    assign w_acc_wide   = {{(c_PROD_W-c_ACC_W){r_acc[c_ACC_W-1]}}, r_acc};
    assign w_prod       = w_acc_wide * c_RECIP;
    assign w_rnd        = w_prod + c_HALF;
    assign w_r          = w_rnd[c_PROD_W-1:24];
    assign w_unused_rnd = ^w_rnd[23:0];

`ifdef GSIM_PE_SAT_EN
    localparam logic signed [c_R_W-1:0] c_SAT_MAX = {{(c_R_W-BIT_WIDTH+1){1'b0}}, {(BIT_WIDTH-1){1'b1}}};
    localparam logic signed [c_R_W-1:0] c_SAT_MIN = {{(c_R_W-BIT_WIDTH+1){1'b1}}, {(BIT_WIDTH-1){1'b0}}};

    always_comb begin
        w_x = w_r[BIT_WIDTH-1:0];
        if (w_r > c_SAT_MAX) begin
            w_x = c_SAT_MAX[BIT_WIDTH-1:0];
        end else if (w_r < c_SAT_MIN) begin
            w_x = c_SAT_MIN[BIT_WIDTH-1:0];
        end
    end
`else
    logic w_unused_r;

    assign w_x        = w_r[BIT_WIDTH-1:0];
    assign w_unused_r = ^w_r[c_R_W-1:BIT_WIDTH];
`endif

    // ------------------------------------------------------------------
    // Pipeline registers; data only loads behind a valid so x_out holds
    // the last real result across bubbles.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_out_valid <= 1'b0;
            r_s1        <= '0;
            r_s2        <= '0;
            r_s3        <= '0;
            r_bq        <= '0;
            r_acc       <= '0;
            r_x_out     <= '0;
        end else if (!w_stall) begin
            r_v1        <= w_accept;
            r_v2        <= r_v1;
            r_out_valid <= r_v2;
            if (w_accept) begin
                r_s1 <= w_s1;
                r_s2 <= w_s2;
                r_s3 <= w_s3;
                r_bq <= w_bq;
            end
            if (r_v1) begin
                r_acc <= w_acc;
            end
            if (r_v2) begin
                r_x_out <= w_x;
            end
        end
    end

    // ------------------------------------------------------------------
    // Result tagging: index within the sweep, completed sweeps, done pulse
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            r_idx  <= 4'd0;
            r_iter <= '0;
            r_done <= 1'b0;
        end else begin
            r_done <= w_consume & w_last;
            if (w_consume) begin
                if (r_idx == 4'd15) begin
                    r_idx <= 4'd0;
                    if (r_iter == c_ITER_LAST) begin
                        r_iter <= '0;
                    end else begin
                        r_iter <= r_iter + c_ITER_W'(1);
                    end
                end else begin
                    r_idx <= r_idx + 4'd1;
                end
            end
        end
    end

    assign bus.in_ready  = ~w_stall;
    assign bus.out_valid = r_out_valid;
    assign bus.x_out     = r_x_out;
    assign bus.out_idx   = r_idx;
    assign bus.iter_cnt  = r_iter;
    assign bus.done      = r_done;

endmodule

`default_nettype wire

// File: tb/tb_gsim_pe.sv
// ============================================================================
// Module : tb_gsim_pe
// Brief  : Directed self-checking bench for gsim_pe (arithmetic, stall, tags).
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_gsim_pe;

    localparam int BIT_WIDTH = 32;
    localparam int B_WIDTH   = 16;
    localparam int ITER_MAX  = 8;
    localparam int IW        = $clog2(ITER_MAX + 1);

    logic clk   = 1'b0;
    logic rst_n = 1'b1;

    always #5 clk = ~clk;

    gsim_pe_if #(.BIT_WIDTH(BIT_WIDTH), .B_WIDTH(B_WIDTH), .ITER_MAX(ITER_MAX)) bus ();

    gsim_pe #(
        .BIT_WIDTH (BIT_WIDTH),
        .B_WIDTH   (B_WIDTH),
        .ITER_MAX  (ITER_MAX),
        .RECIP     (838861)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int pass_cnt  = 0;
    int total_cnt = 0;
    int exp_idx   = 0;

    task automatic drive_set(input logic [31:0] b, input logic [31:0] m1, input logic [31:0] p1,
                             input logic [31:0] m2, input logic [31:0] p2,
                             input logic [31:0] m3, input logic [31:0] p3);
        bus.in_valid = 1'b1;
        bus.b_in     = b[B_WIDTH-1:0];
        bus.x_m1     = m1;
        bus.x_p1     = p1;
        bus.x_m2     = m2;
        bus.x_p2     = p2;
        bus.x_m3     = m3;
        bus.x_p3     = p3;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.x_out !== 32'h0 || bus.out_idx !== 4'd0 ||
            bus.iter_cnt !== '0 || bus.done !== 1'b0) begin
            $display("FAIL reset_state: got valid=%b x=%h idx=%0d iter=%0d done=%b required 0/0/0/0/0",
                     bus.out_valid, bus.x_out, bus.out_idx, bus.iter_cnt, bus.done);
        end else pass_cnt++;
        rst_n = 1'b0;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b required 1", bus.in_ready);
        else pass_cnt++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_arith();
        logic [31:0] vec [0:5][0:7];
        logic [31:0] exp_big;
`ifdef GSIM_PE_SAT_EN
        exp_big = 32'h7FFFFFFF;
`else
        exp_big = 32'hB3332932;
`endif
        //         b      m1            p1            m2            p2            m3            p3            expected
        vec[0] = '{32'd20, 32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h0,        32'h00010000};
        vec[1] = '{32'd0,  32'h00010000, 32'h00010000, 32'h0,        32'h0,        32'h0,        32'h0,        32'h00014CCD};
        vec[2] = '{32'd0,  32'h0,        32'h0,        32'h00010000, 32'h00010000, 32'h0,        32'h0,        32'hFFFF6666};
        vec[3] = '{32'd0,  32'h0,        32'h0,        32'h0,        32'h0,        32'h00010000, 32'h00010000, 32'h0000199A};
        vec[4] = '{32'd65535, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h0,     32'h0,        32'h0,        32'h0,        exp_big};
        vec[5] = '{32'd40, 32'h00010000, 32'hFFFF0000, 32'h0,        32'h0,        32'h0,        32'h0,        32'h00020000};
        bus.out_ready = 1'b1;
        for (int v = 0; v < 6; v++) begin
            drive_set(vec[v][0], vec[v][1], vec[v][2], vec[v][3], vec[v][4], vec[v][5], vec[v][6]);
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            @(posedge clk);
            @(posedge clk);
            #1;
            total_cnt++;
            if (bus.out_valid !== 1'b1) $display("FAIL arith%0d_valid: got %b required 1", v, bus.out_valid);
            else pass_cnt++;
            total_cnt++;
            if (bus.x_out !== vec[v][7]) $display("FAIL arith%0d_x: got %h required %h", v, bus.x_out, vec[v][7]);
            else pass_cnt++;
            total_cnt++;
            if (bus.out_idx !== 4'(exp_idx)) $display("FAIL arith%0d_idx: got %0d required %0d", v, bus.out_idx, exp_idx);
            else pass_cnt++;
            exp_idx++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive_set(32'd20, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive_set(32'd40, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        drive_set(32'd60, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        total_cnt++;
        if (bus.in_ready !== 1'b0 || bus.out_valid !== 1'b1)
            $display("FAIL bp_stall_start: got in_ready=%b out_valid=%b required 0/1", bus.in_ready, bus.out_valid);
        else pass_cnt++;
        repeat (5) @(posedge clk);
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b0) $display("FAIL bp_in_ready: got %b required 0", bus.in_ready);
        else pass_cnt++;
        total_cnt++;
        if (bus.x_out !== 32'h00010000 || bus.out_idx !== 4'(exp_idx))
            $display("FAIL bp_hold: got x=%h idx=%0d required 00010000/%0d", bus.x_out, bus.out_idx, exp_idx);
        else pass_cnt++;
        bus.out_ready = 1'b1;
        #1;
        total_cnt++;
        if (bus.in_ready !== 1'b1) $display("FAIL bp_release_ready: got %b required 1", bus.in_ready);
        else pass_cnt++;
        @(posedge clk); #1;
        exp_idx++;
        total_cnt++;
        if (bus.x_out !== 32'h00020000 || bus.out_idx !== 4'(exp_idx))
            $display("FAIL bp_second: got x=%h idx=%0d required 00020000/%0d", bus.x_out, bus.out_idx, exp_idx);
        else pass_cnt++;
        @(posedge clk); #1;
        exp_idx++;
        total_cnt++;
        if (bus.x_out !== 32'h00030000 || bus.out_valid !== 1'b1)
            $display("FAIL bp_third: got x=%h valid=%b required 00030000/1", bus.x_out, bus.out_valid);
        else pass_cnt++;
        @(posedge clk); #1;
        exp_idx++;
        total_cnt++;
        if (bus.out_valid !== 1'b0 || bus.out_idx !== 4'(exp_idx))
            $display("FAIL bp_drain: got valid=%b idx=%0d required 0/%0d", bus.out_valid, bus.out_idx, exp_idx);
        else pass_cnt++;
    endtask

    task automatic test_mid_reset();
        bit seen_valid;
        total_cnt++;
        if (bus.out_idx !== 4'(exp_idx)) $display("FAIL mrst_pre_idx: got %0d required %0d", bus.out_idx, exp_idx);
        else pass_cnt++;
        drive_set(32'd20, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        total_cnt++;
        if (bus.out_idx !== 4'd0 || bus.iter_cnt !== '0 || bus.out_valid !== 1'b0)
            $display("FAIL mrst_clear: got idx=%0d iter=%0d valid=%b required 0/0/0",
                     bus.out_idx, bus.iter_cnt, bus.out_valid);
        else pass_cnt++;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_idx = 0;
        seen_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk); #1;
            if (bus.out_valid !== 1'b0) seen_valid = 1'b1;
        end
        total_cnt++;
        if (seen_valid) $display("FAIL mrst_flush: got out_valid=1 after reset required 0");
        else pass_cnt++;
    endtask

    task automatic test_done();
        int  cons_n = 0;
        int  acc_n  = 0;
        int  done_n = 0;
        int  exp_i;
        int  exp_it;
        bit  will_acc;
        bit  will_cons;
        bus.out_ready = 1'b1;
        drive_set(32'd20, 0, 0, 0, 0, 0, 0);
        for (int cyc = 0; cyc < 300 && cons_n < 16*ITER_MAX; cyc++) begin
            will_acc  = bus.in_valid && bus.in_ready;
            will_cons = bus.out_valid && bus.out_ready;
            @(posedge clk); #1;
            if (will_acc) begin
                acc_n++;
                if (acc_n == 16*ITER_MAX) bus.in_valid = 1'b0;
            end
            if (bus.done === 1'b1) done_n++;
            if (will_cons) begin
                cons_n++;
                exp_i  = cons_n % 16;
                exp_it = (cons_n / 16) % ITER_MAX;
                total_cnt++;
                if (bus.out_idx !== exp_i[3:0] || bus.iter_cnt !== exp_it[IW-1:0])
                    $display("FAIL cnt_%0d: got idx=%0d iter=%0d required %0d/%0d",
                             cons_n, bus.out_idx, bus.iter_cnt, exp_i, exp_it);
                else pass_cnt++;
                if (cons_n == 16*ITER_MAX) begin
                    total_cnt++;
                    if (bus.done !== 1'b1) $display("FAIL done_pulse: got %b required 1", bus.done);
                    else pass_cnt++;
                end
            end
        end
        total_cnt++;
        if (cons_n != 16*ITER_MAX) $display("FAIL done_timeout: got %0d consumes required %0d", cons_n, 16*ITER_MAX);
        else pass_cnt++;
        @(posedge clk); #1;
        if (bus.done === 1'b1) done_n++;
        total_cnt++;
        if (bus.done !== 1'b0 || done_n != 1)
            $display("FAIL done_single: got done=%b pulses=%0d required 0/1", bus.done, done_n);
        else pass_cnt++;
        total_cnt++;
        if (bus.out_valid !== 1'b0) $display("FAIL done_drain: got valid=%b required 0", bus.out_valid);
        else pass_cnt++;
    endtask

    initial begin
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.b_in      = '0;
        bus.x_m1      = '0;
        bus.x_p1      = '0;
        bus.x_m2      = '0;
        bus.x_p2      = '0;
        bus.x_m3      = '0;
        bus.x_p3      = '0;
        test_reset();
        test_arith();
        test_backpressure();
        test_mid_reset();
        test_done();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got no completion required finish before 200000");
        $fatal(1, "watchdog expired");
    end

endmodule

`default_nettype wire

// File: doc/gsim_pe.md
Name: gsim_pe

Overview:
- Downstream compute stage of the GSIM solver. Consumes the seven taps presented by the 16-entry unknown shift register, plus the right-hand-side value b.
- Per accepted operand set, computes one Gauss-Seidel update: x_new = (b + 13(x[i-1]+x[i+1]) - 6(x[i-2]+x[i+2]) + (x[i-3]+x[i+3])) / 20.
- 3-stage pipeline with valid/ready handshake and global stall.
- Tags each result with its unknown index and iteration count; pulses done after the last iteration.

Parameters:
- BIT_WIDTH, 32, width of x values; signed Q(BIT_WIDTH-16).16 fixed point.
- B_WIDTH, 16, width of b; unsigned integer.
- ITER_MAX, 8, number of 16-result sweeps before done pulses.
- RECIP, 838861, round(2^24/20), reciprocal constant for the divide.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- in_valid  in  1  operand set valid.
- in_ready  out  1  pipeline can accept this cycle.
- b_in  in  B_WIDTH  unsigned b for the current unknown.
- x_m1, x_p1  in  BIT_WIDTH each  neighbours at distance 1.
- x_m2, x_p2  in  BIT_WIDTH each  neighbours at distance 2.
- x_m3, x_p3  in  BIT_WIDTH each  neighbours at distance 3.
- out_valid  out  1  x_out valid.
- out_ready  in  1  consumer accepts x_out.
- x_out  out  BIT_WIDTH  updated unknown, signed Q.16.
- out_idx  out  4  index 0..15 of the result on x_out.
- iter_cnt  out  $clog2(ITER_MAX+1)  completed sweeps.
- done  out  1  one-cycle pulse when the final sweep's last result is accepted.

Behaviour:
- Reset: all stage valids 0, out_valid 0, x_out 0, out_idx 0, iter_cnt 0, done 0. All pipeline data registers 0.
- Reset is asynchronous and may assert mid-operation: in-flight data is discarded and counters clear.
- Stall:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall (combinational).
  - While stall is high, every stage register holds its value.
  - Accept occurs when in_valid & in_ready.
- Stage 1 (on accept):
  - s1 = x_m1+x_p1, s2 = x_m2+x_p2, s3 = x_m3+x_p3, each sign-extended to BIT_WIDTH+1.
  - bq = b_in << 16, zero-extended.
  - v1 = accept.
- Stage 2: acc = bq + 13*s1 - 6*s2 + s3 in 40-bit signed (no overflow possible at defaults). v2 = v1.
- Stage 3:
  - p = acc*RECIP, 64-bit signed.
  - r = (p + 2^23) >>> 24, i.e. round half toward +inf.
  - x_out = sat(r), see Optional Feature. out_valid = v2.
- Latency: result is on x_out exactly 3 clk edges after acceptance, absent stalls. Throughput is 1 per cycle.
- Bubbles (in_valid low) propagate as invalid stages and are not counted. Order is preserved.
- Output handshake:
  - A result is consumed on out_valid & out_ready.
  - On consume, out_idx increments and wraps 15 -> 0.
  - On wrap, iter_cnt increments.
- Final consume:
  - Occurs at out_idx==15 with iter_cnt==ITER_MAX-1.
  - done is high during the cycle following that consume edge.
  - iter_cnt and out_idx both return to 0.
- Simultaneous consume and new accept in the same cycle is legal; the pipeline advances.

Optional Feature:
- Macro: GSIM_PE_SAT_EN.
- Defined: r is clamped to [-2^(BIT_WIDTH-1), 2^(BIT_WIDTH-1)-1].
- Undefined: x_out = r[BIT_WIDTH-1:0], two's-complement wrap, no clamp logic.

Test Plan:
- Reset behaviour: rst_n pulsed high -> out_valid=0, x_out=0, out_idx=0, iter_cnt=0, done=0; in_ready=1 once rst_n is low.
- b_in=20, all x=0 -> 3 cycles later x_out=0x00010000 (1.0), out_idx=0.
- b_in=0, x_m1=x_p1=0x00010000, others 0 -> x_out=0x00014CCD.
- b_in=0, x_m2=x_p2=0x00010000, others 0 -> x_out=0xFFFF6666 (-39322 raw).
- b_in=65535, x_m1=x_p1=0x7FFFFFFF, others 0:
  - With GSIM_PE_SAT_EN -> x_out=0x7FFFFFFF.
  - Without -> low 32 bits of r.
- Backpressure and counters:
  - Stream 3 sets with out_ready=0 for 5 cycles -> in_ready=0 while stalled, x_out held, all 3 results emerge in order once out_ready=1.
  - 16*ITER_MAX consumes -> single done pulse, then out_idx=0 and iter_cnt=0.
  - rst_n asserted mid-sweep -> counters and valids clear immediately.
